cpu_cmd_issuer: RTL

Sits directly upstream of cpu_main and feeds it. Buffers host ALU commands (opcode, a, b) in a small FIFO and presents one at a time on cpu_main's operand inputs. Holds the operands stable until cpu_main asserts done, or until a timeout expires. Captures the result and returns it to the host over a valid/ready response channel.

---
 rtl/cpu_issuer_pkg.sv | 19 +
 rtl/cpu_cmd_fifo.sv | 59 +++++
 rtl/cpu_cmd_issuer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_issuer_pkg.sv
// Shared types for the CPU command issuer: FSM state encoding and the queued command format.
package cpu_issuer_pkg;
    localparam int OPCODE_W   = 8;
    // Operand field width of a queued command; the issuer's W must not exceed it.
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [CMD_DATA_W-1:0] a;
        logic [CMD_DATA_W-1:0] b;
    } cmd_t;
endpackage

// File: rtl/cpu_cmd_fifo.sv
// Synchronous FIFO with a registered full flag; dout shows the head entry combinationally.
module cpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_full;
    logic          w_push, w_pop;

    assign w_push = push && !r_full;
    assign w_pop  = pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    // Full is registered from the next count so the ready seen upstream is a clean flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = (r_count == '0);
    assign count = r_count;
endmodule

// File: rtl/cpu_cmd_issuer.sv
// Queues host ALU commands and issues them one at a time to cpu_main, holding operands
// until done or timeout, then returns the result over a valid/ready response channel.
module cpu_cmd_issuer
    import cpu_issuer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 64,
    parameter int W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    input  logic [W-1:0]        cmd_a,
    input  logic [W-1:0]        cmd_b,
    output logic [OPCODE_W-1:0] cpu_opcode,
    output logic [W-1:0]        cpu_a,
    output logic [W-1:0]        cpu_b,
    input  logic [W-1:0]        cpu_result,
    input  logic                cpu_done,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [OPCODE_W-1:0] rsp_opcode,
    output logic [W-1:0]        rsp_result,
    output logic                rsp_error,
    output logic                busy
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t                 r_state, w_state_nxt;
    cmd_t                   w_push_cmd, w_head;
    logic                   w_full, w_empty, w_push, w_launch;
    logic                   w_done_hit, w_timeout_hit;
    logic [$clog2(DEPTH):0] w_count;
    logic [SW-1:0]          r_settle_cnt;
    logic [TW-1:0]          r_timer;
    logic [OPCODE_W-1:0]    r_cpu_opcode, r_rsp_opcode;
    logic [W-1:0]           r_cpu_a, r_cpu_b, r_rsp_result;
    logic                   r_rsp_error;

    assign w_push     = cmd_valid && !w_full;
    assign w_push_cmd = '{opcode: cmd_opcode, a: CMD_DATA_W'(cmd_a), b: CMD_DATA_W'(cmd_b)};

    cpu_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_launch),
        .din   (w_push_cmd),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // A launch from RESPOND rides the response handshake edge, so there is no IDLE bubble.
    assign w_launch      = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_RESPOND && rsp_ready));
    assign w_done_hit    = (r_state == ST_WAIT_DONE) && cpu_done;
    assign w_timeout_hit = (r_state == ST_WAIT_DONE) && !cpu_done && (r_timer == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_launch) w_state_nxt = ST_SETTLE;
            ST_SETTLE:    if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_done_hit || w_timeout_hit) w_state_nxt = ST_RESPOND;
            ST_RESPOND:   if (rsp_ready) w_state_nxt = w_launch ? ST_SETTLE : ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_opcode <= '0;
            r_cpu_a      <= '0;
            r_cpu_b      <= '0;
            r_settle_cnt <= '0;
            r_timer      <= '0;
            r_rsp_opcode <= '0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_launch) begin
                r_cpu_opcode <= w_head.opcode;
                r_cpu_a      <= W'(w_head.a);
                r_cpu_b      <= W'(w_head.b);
                r_settle_cnt <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            // Timer only runs in WAIT_DONE, so it is always clear on entry.
            if (r_state != ST_WAIT_DONE) r_timer <= '0;
            else if (!cpu_done)          r_timer <= r_timer + 1'b1;
            if (w_done_hit) begin
                r_rsp_opcode <= r_cpu_opcode;
                r_rsp_result <= cpu_result;
                r_rsp_error  <= 1'b0;
            end else if (w_timeout_hit) begin
                r_rsp_opcode <= r_cpu_opcode;
                r_rsp_result <= '0;
                r_rsp_error  <= 1'b1;
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign cpu_opcode = r_cpu_opcode;
    assign cpu_a      = r_cpu_a;
    assign cpu_b      = r_cpu_b;
    assign rsp_valid  = (r_state == ST_RESPOND);
    assign rsp_opcode = r_rsp_opcode;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;
    assign busy       = (r_state != ST_IDLE) || (w_count != '0);
endmodule
